// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU request scheduler: opcodes, FSM states,
// response error codes and the accept-time reject classifier.
package alu_ctrl_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_REM  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_NAND = 4'd7;
    localparam logic [3:0] OP_NOR  = 4'd8;
    localparam logic [3:0] OP_XOR  = 4'd9;
    localparam logic [3:0] OP_SHL  = 4'd10;
    localparam logic [3:0] OP_SHR  = 4'd11;
    localparam logic [3:0] OP_ROL  = 4'd12;
    localparam logic [3:0] OP_ROR  = 4'd13;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_DIV0    = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    // Commands that are answered without ever touching the ALU.
    function automatic logic [1:0] reject_code(input logic [3:0] op, input logic [15:0] b);
        if (op == 4'hE || op == 4'hF) begin
            return ERR_ILLEGAL;
        end else if (op == OP_DIV && b == 16'd0) begin
            return ERR_DIV0;
        end else begin
            return ERR_OK;
        end
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-grant flop moves only on the update strobe.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_update,
    output logic o_gnt0,
    output logic o_gnt1
);

    // r_last1 = 1 means requester 1 was granted last; reset value lets req0 win the first tie.
    logic r_last1;

    // Last-grant pointer, moved to the winner when a grant is consumed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last1 <= 1'b1;
        end else if (i_update) begin
            r_last1 <= o_gnt1;
        end
    end

    // A sole requester wins; on a tie the one not granted last wins.
    always_comb begin
        o_gnt0 = i_req0 && (!i_req1 || r_last1);
        o_gnt1 = i_req1 && (!i_req0 || !r_last1);
    end

endmodule

// File: rtl/alu_req_scheduler.sv
// Accepts commands from two requesters, sequences one ALU operation at a time
// (PREP -> ISSUE -> WAIT) and returns a one-cycle response to the requester.
module alu_req_scheduler
    import alu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic               req1_valid,
    output logic               req0_ready,
    output logic               req1_ready,
    input  logic [3:0]         req0_op,
    input  logic [3:0]         req1_op,
    input  logic signed [15:0] req0_a,
    input  logic signed [15:0] req1_a,
    input  logic signed [15:0] req0_b,
    input  logic signed [15:0] req1_b,
    output logic               rsp0_valid,
    output logic               rsp1_valid,
    output logic signed [15:0] rsp_low,
    output logic signed [15:0] rsp_high,
    output logic [1:0]         rsp_err,
    output logic               alu_en,
    output logic               alu_start,
    output logic [3:0]         alu_op,
    output logic signed [15:0] alu_a,
    output logic signed [15:0] alu_b,
    input  logic [15:0]        alu_z_low,
    input  logic [15:0]        alu_z_high,
    input  logic               alu_valid,
    output logic               busy
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e              r_state;
    state_e              w_next;
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_accept;
    logic [3:0]          w_in_op;
    logic signed [15:0]  w_in_a;
    logic signed [15:0]  w_in_b;
    logic [1:0]          w_rej;
    logic                w_timeout;
    logic [3:0]          r_op;
    logic signed [15:0]  r_a;
    logic signed [15:0]  r_b;
    logic                r_id;
    logic                r_alu_en;
    logic [CNT_W-1:0]    r_cnt;
    logic signed [15:0]  r_rsp_low;
    logic signed [15:0]  r_rsp_high;
    logic [1:0]          r_rsp_err;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req0   (req0_valid),
        .i_req1   (req1_valid),
        .i_update (w_accept),
        .o_gnt0   (w_gnt0),
        .o_gnt1   (w_gnt1)
    );

    // Mux the granted requester's fields and classify them for early reject.
    always_comb begin
        w_accept  = (r_state == ST_IDLE) && (w_gnt0 || w_gnt1);
        w_in_op   = w_gnt1 ? req1_op : req0_op;
        w_in_a    = w_gnt1 ? req1_a  : req0_a;
        w_in_b    = w_gnt1 ? req1_b  : req0_b;
        w_rej     = reject_code(w_in_op, w_in_b);
        w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; rejects bypass the ALU, alu_valid beats a same-cycle timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = (w_rej != ERR_OK) ? ST_RESP : ST_PREP;
            ST_PREP:  w_next = ST_ISSUE;
            ST_ISSUE: w_next = ST_WAIT;
            ST_WAIT:  if (alu_valid || w_timeout) w_next = ST_RESP;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Handshake, start pulse, response strobes and busy decoded from the state.
    always_comb begin
        req0_ready = (r_state == ST_IDLE) && w_gnt0;
        req1_ready = (r_state == ST_IDLE) && w_gnt1;
        alu_start  = (r_state == ST_ISSUE);
        rsp0_valid = (r_state == ST_RESP) && !r_id;
        rsp1_valid = (r_state == ST_RESP) && r_id;
        busy       = (r_state != ST_IDLE);
    end

    // ALU clock enable is registered from the next state so its gated clock is glitch-free.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_alu_en <= 1'b0;
        end else begin
            r_alu_en <= (w_next == ST_PREP) || (w_next == ST_ISSUE) || (w_next == ST_WAIT);
        end
    end

    // Latch the accepted command; operands then stay stable for the whole ALU run.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_op <= 4'd0;
            r_a  <= 16'sd0;
            r_b  <= 16'sd0;
            r_id <= 1'b0;
        end else if (w_accept) begin
            r_op <= w_in_op;
            r_a  <= w_in_a;
            r_b  <= w_in_b;
            r_id <= w_gnt1;
        end
    end

    // WAIT-cycle counter, cleared whenever the FSM is elsewhere.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // Response data/error, updated only on the way into RESP and held afterwards.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rsp_low  <= 16'sd0;
            r_rsp_high <= 16'sd0;
            r_rsp_err  <= ERR_OK;
        end else if (w_accept && (w_rej != ERR_OK)) begin
            r_rsp_low  <= 16'sd0;
            r_rsp_high <= 16'sd0;
            r_rsp_err  <= w_rej;
        end else if (r_state == ST_WAIT) begin
            if (alu_valid) begin
                r_rsp_low  <= $signed(alu_z_low);
                r_rsp_high <= $signed(alu_z_high);
                r_rsp_err  <= ERR_OK;
            end else if (w_timeout) begin
                r_rsp_low  <= 16'sd0;
                r_rsp_high <= 16'sd0;
                r_rsp_err  <= ERR_TIMEOUT;
            end
        end
    end

    assign alu_en   = r_alu_en;
    assign alu_op   = r_op;
    assign alu_a    = r_a;
    assign alu_b    = r_b;
    assign rsp_low  = r_rsp_low;
    assign rsp_high = r_rsp_high;
    assign rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Self-checking bench for alu_req_scheduler with a behavioural ALU responder.
module tb_alu_req_scheduler;
    import alu_ctrl_pkg::*;

    localparam int TO = 40;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               req0_valid = 1'b0, req1_valid = 1'b0;
    logic               req0_ready, req1_ready;
    logic [3:0]         req0_op = 4'd0, req1_op = 4'd0;
    logic signed [15:0] req0_a = 16'sd0, req1_a = 16'sd0, req0_b = 16'sd0, req1_b = 16'sd0;
    logic               rsp0_valid, rsp1_valid;
    logic signed [15:0] rsp_low, rsp_high;
    logic [1:0]         rsp_err;
    logic               alu_en, alu_start;
    logic [3:0]         alu_op;
    logic signed [15:0] alu_a, alu_b;
    logic [15:0]        alu_z_low = 16'd0, alu_z_high = 16'd0;
    logic               alu_valid = 1'b0;
    logic               busy;

    alu_req_scheduler #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_low(rsp_low), .rsp_high(rsp_high), .rsp_err(rsp_err),
        .alu_en(alu_en), .alu_start(alu_start), .alu_op(alu_op),
        .alu_a(alu_a), .alu_b(alu_b),
        .alu_z_low(alu_z_low), .alu_z_high(alu_z_high), .alu_valid(alu_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                 id;
        logic [3:0]         op;
        logic signed [15:0] a;
        logic signed [15:0] b;
        logic [15:0]        lo;
        logic [15:0]        hi;
        logic [1:0]         err;
        int                 lat;
        int                 dly;   // ALU response delay in WAIT cycles, 0 = never
    } vec_t;

    typedef struct {
        int          id;
        logic [15:0] lo;
        logic [15:0] hi;
        logic [1:0]  err;
        int          lat;
        int          starts;
        int          ens;
        int          cyc0;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[10];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   alu_delay = 1;
    bit   spur = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic signed [15:0] a,
                                            input logic signed [15:0] b);
        int ai;
        int bi;
        ai = a;
        bi = b;
        case (op)
            OP_ADD:  return ai + bi;
            OP_SUB:  return ai - bi;
            OP_MUL:  return ai * bi;
            OP_DIV:  return (bi != 0) ? {16'(ai % bi), 16'(ai / bi)} : 32'd0;
            OP_XOR:  return ai ^ bi;
            default: return ai + bi;
        endcase
    endfunction

    // Behavioural ALU: result appears alu_delay cycles after the start pulse.
    int                 pend = 0;
    logic [3:0]         m_op;
    logic signed [15:0] m_a, m_b;
    always @(negedge clk) begin
        alu_valid = 1'b0;
        if (spur) begin
            alu_valid  = 1'b1;
            alu_z_low  = 16'hDEAD;
            alu_z_high = 16'hBEEF;
        end
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                alu_valid = 1'b1;
                {alu_z_high, alu_z_low} = alu_ref(m_op, m_a, m_b);
            end
        end
        if (alu_start && alu_en) begin
            pend = alu_delay;
            m_op = alu_op;
            m_a  = alu_a;
            m_b  = alu_b;
        end
        if (!rst) pend = 0;
    end

    // Response monitor: pops the scoreboard on every response pulse.
    int   m_starts = 0;
    int   m_ens = 0;
    exp_t me;
    always @(negedge clk) begin
        if (!rst) begin
            m_starts = 0;
            m_ens    = 0;
        end else begin
            if (alu_start) m_starts++;
            if (alu_en) m_ens++;
            if (rsp0_valid || rsp1_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
                end else begin
                    me = sbq.pop_front();
                    chk("rsp_id", {30'd0, rsp1_valid, rsp0_valid}, (me.id != 0) ? 32'd2 : 32'd1);
                    chk("rsp_low", {16'd0, $unsigned(rsp_low)}, {16'd0, me.lo});
                    chk("rsp_high", {16'd0, $unsigned(rsp_high)}, {16'd0, me.hi});
                    chk("rsp_err", {30'd0, rsp_err}, {30'd0, me.err});
                    chk("rsp_latency", cyc - me.cyc0, me.lat);
                    chk("alu_start_count", m_starts, me.starts);
                    chk("alu_en_cycles", m_ens, me.ens);
                    chk("resp_alu_en_start", {30'd0, alu_en, alu_start}, 32'd0);
                end
                m_starts = 0;
                m_ens    = 0;
            end
        end
    end

    task automatic drive_req(input int id, input bit v, input logic [3:0] op,
                             input logic signed [15:0] a, input logic signed [15:0] b);
        if (id == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    task automatic send(input vec_t v, input bit expect_rsp);
        int   k;
        exp_t e;
        bit   rej;
        @(negedge clk);
        alu_delay = v.dly;
        drive_req(v.id, 1'b1, v.op, v.a, v.b);
        #1;
        k = 0;
        while (!((v.id == 0) ? req0_ready : req1_ready) && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("accept_wait", {31'd0, k < 200}, 32'd1);
        rej      = (v.err == ERR_DIV0) || (v.err == ERR_ILLEGAL);
        e.id     = v.id;
        e.lo     = v.lo;
        e.hi     = v.hi;
        e.err    = v.err;
        e.lat    = v.lat;
        e.starts = rej ? 0 : 1;
        e.ens    = rej ? 0 : ((v.dly == 0) ? TO + 2 : 2 + v.dly);
        e.cyc0   = cyc;
        if (expect_rsp && k < 200) sbq.push_back(e);
        @(posedge clk);
        #1;
        drive_req(v.id, 1'b0, v.op, v.a, v.b);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while ((sbq.size() != 0 || busy) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("drain", {31'd0, k < 300}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k;
        int   exp_id;
        exp_t e;

        tbl[0] = '{0, OP_ADD, 16'sd100,  -16'sd30, 16'h0046, 16'h0000, ERR_OK,      4, 1};
        tbl[1] = '{1, OP_MUL, -16'sd300, 16'sd200, 16'h15A0, 16'hFFFF, ERR_OK,      4, 1};
        tbl[2] = '{0, OP_DIV, 16'sd77,   16'sd0,   16'h0000, 16'h0000, ERR_DIV0,    1, 1};
        tbl[3] = '{1, 4'hF,   16'sd5,    16'sd6,   16'h0000, 16'h0000, ERR_ILLEGAL, 1, 1};
        tbl[4] = '{0, 4'hE,   16'sd5,    16'sd6,   16'h0000, 16'h0000, ERR_ILLEGAL, 1, 1};
        tbl[5] = '{1, OP_SUB, 16'sd5,    16'sd9,   16'hFFFC, 16'hFFFF, ERR_OK,      4, 1};
        tbl[6] = '{0, OP_XOR, 16'sh00FF, 16'sh0F0F, 16'h0FF0, 16'h0000, ERR_OK,     4, 1};
        tbl[7] = '{1, OP_DIV, 16'sd100,  16'sd7,   16'h000E, 16'h0002, ERR_OK,      4, 1};
        tbl[8] = '{0, OP_ADD, 16'sd1,    16'sd2,   16'h0000, 16'h0000, ERR_TIMEOUT, 43, 0};
        tbl[9] = '{1, OP_ADD, 16'sd1,    16'sd2,   16'h0003, 16'h0000, ERR_OK,      43, 40};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {27'd0, busy, alu_en, alu_start, rsp0_valid, rsp1_valid}, 32'd0);
        chk("reset_rsp_low", {16'd0, $unsigned(rsp_low)}, 32'd0);
        chk("reset_rsp_high", {16'd0, $unsigned(rsp_high)}, 32'd0);
        chk("reset_rsp_err", {30'd0, rsp_err}, 32'd0);
        chk("reset_alu_op", {28'd0, alu_op}, 32'd0);
        chk("reset_alu_ab", {$unsigned(alu_a), $unsigned(alu_b)}, 32'd0);
        rst = 1'b1;

        // Both requesters valid from reset: expect grants 0, 1, 0
        @(negedge clk);
        alu_delay = 1;
        drive_req(0, 1'b1, OP_XOR, 16'sh1234, 16'sh00FF);
        drive_req(1, 1'b1, OP_XOR, 16'sh0F0F, -16'sd1);
        exp_id = 0;
        for (int t = 0; t < 3; t++) begin
            #1;
            k = 0;
            while (!(req0_ready || req1_ready) && k < 200) begin
                @(negedge clk);
                #1;
                k++;
            end
            chk("arb_wait", {31'd0, k < 200}, 32'd1);
            chk($sformatf("arb_grant%0d", t), {30'd0, req1_ready, req0_ready},
                (exp_id != 0) ? 32'd2 : 32'd1);
            e.id     = exp_id;
            e.lo     = (exp_id != 0) ? 16'hF0F0 : 16'h12CB;
            e.hi     = (exp_id != 0) ? 16'hFFFF : 16'h0000;
            e.err    = ERR_OK;
            e.lat    = 4;
            e.starts = 1;
            e.ens    = 3;
            e.cyc0   = cyc;
            sbq.push_back(e);
            @(posedge clk);
            exp_id = 1 - exp_id;
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();

        // Table of single-requester commands
        for (int i = 0; i < 10; i++) begin
            send(tbl[i], 1'b1);
            wait_idle();
        end

        // alu_valid outside WAIT must not disturb the held response
        @(posedge clk);
        spur = 1'b1;
        @(posedge clk);
        spur = 1'b0;
        repeat (2) @(negedge clk);
        chk("spurious_valid_low", {16'd0, $unsigned(rsp_low)}, 32'h0003);
        chk("spurious_valid_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of a MUL's WAIT phase aborts silently
        send('{1, OP_MUL, -16'sd300, 16'sd200, 16'h0000, 16'h0000, ERR_OK, 4, 0}, 1'b0);
        repeat (6) @(negedge clk);
        chk("pre_abort_in_wait", {30'd0, busy, alu_en}, 32'd3);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_state", {28'd0, busy, alu_en, alu_start, rsp0_valid | rsp1_valid}, 32'd0);
        rst = 1'b1;
        send('{0, OP_ADD, 16'sd100, -16'sd30, 16'h0046, 16'h0000, ERR_OK, 4, 1}, 1'b1);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
